// File: rtl/uni2bin_acc_pkg.sv
// Shared definitions for the unary-to-binary accumulator and its downstream register stage.
package uni2bin_acc_pkg;

  // Binary result width; one conversion window is 2**DEF_BITWIDTH cycles long.
  localparam int unsigned DEF_BITWIDTH = 4;

endpackage : uni2bin_acc_pkg

// File: rtl/uni2bin_acc.sv
// Unary-to-binary converter: counts the ones of iBit over a 2**BITWIDTH-cycle window
// started by iStart, then presents the saturated count on oData with a one-cycle oValid.
module uni2bin_acc
  import uni2bin_acc_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iBit,
  output logic [BITWIDTH-1:0] oData,
  output logic                oValid,
  output logic                oBusy
);

  // One extra accumulator bit so an all-ones window (2**BITWIDTH) cannot wrap to zero.
  localparam int unsigned ACC_W = BITWIDTH + 1;

  localparam logic [BITWIDTH-1:0] DATA_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  state_t              state;
  logic [BITWIDTH-1:0] winCnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    accNext;

  // Accumulator value including the sample taken on this edge.
  always_comb begin
    accNext = acc + ACC_W'(iBit);
  end

  // Window FSM, inline window counter, accumulator and registered outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      winCnt <= '0;
      acc    <= '0;
      oData  <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
    end else if (iClr) begin
      state  <= IDLE;
      winCnt <= '0;
      acc    <= '0;
      oData  <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state  <= RUN;
            winCnt <= '0;
            acc    <= '0;
            oBusy  <= 1'b1;
          end
        end
        RUN: begin
          // iStart is deliberately ignored here; a window always runs to completion.
          acc    <= accNext;
          winCnt <= winCnt + BITWIDTH'(1);
          if (winCnt == DATA_MAX) begin
            state  <= DONE;
            oBusy  <= 1'b0;
            oValid <= 1'b1;
            oData  <= accNext[BITWIDTH] ? DATA_MAX : accNext[BITWIDTH-1:0];
          end
        end
        DONE: begin
          if (iStart) begin
            state  <= RUN;
            winCnt <= '0;
            acc    <= '0;
            oBusy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule : uni2bin_acc

// File: doc/uni2bin_acc.md
UNI2BIN_ACC -- requirements
Module: uni2bin_acc

Interface
REQ-001 SHALL have parameter BITWIDTH, default `BITWIDTH from the shared definitions, binary result width; window length is 2^BITWIDTH cycles.
REQ-002 SHALL have iClk  input  1  clock, rising edge.
REQ-003 SHALL have iRstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have iClr  input  1  synchronous clear, abort any conversion.
REQ-005 SHALL have iStart  input  1  start-conversion request.
REQ-006 SHALL have iBit  input  1  unary bitstream input.
REQ-007 SHALL have oData  output  BITWIDTH  binary count of ones in last completed window.
REQ-008 SHALL have oValid  output  1  one-cycle pulse, oData updated this cycle; drives downstream register iEn.
REQ-009 SHALL have oBusy  output  1  high while a window is being sampled.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 IDLE: iStart=1 -> RUN next cycle, window counter and accumulator loaded 0; iStart=0 -> stay IDLE.
REQ-012 RUN: sample iBit every cycle; accumulator += iBit; window counter += 1.
REQ-013 RUN SHALL last exactly 2^BITWIDTH cycles; on the sample where window counter == 2^BITWIDTH-1 -> DONE.
REQ-014 iStart during RUN SHALL be ignored; no restart, no counter effect.
REQ-015 Accumulator SHALL be BITWIDTH+1 bits internally; no wrap-around.
REQ-016 DONE: oData <= min(accumulator, 2^BITWIDTH-1) (saturate all-ones window to max), oValid=1 for that one cycle.
REQ-017 DONE lasts one cycle; iStart=1 in DONE -> RUN (back-to-back, counters reloaded 0); else -> IDLE.
REQ-018 Latency: iStart sampled at edge k -> samples at edges k+1..k+2^BITWIDTH -> oValid high in cycle after last sample.
REQ-019 oData SHALL hold its value in IDLE and RUN until next DONE.
REQ-020 oBusy SHALL be 1 exactly in RUN.
REQ-021 iClr=1 SHALL take priority over iStart and FSM: next state IDLE, counters 0, oData 0, oValid 0.
REQ-022 oValid SHALL never be high two consecutive cycles except back-to-back windows are impossible faster than 2^BITWIDTH+1 cycles apart.

Reset
REQ-023 iRstN=0 SHALL asynchronously force IDLE, window counter 0, accumulator 0, oData 0, oValid 0, oBusy 0.
REQ-024 Reset mid-RUN SHALL discard the partial window; no oValid after reset release until a new iStart completes.

Structure
REQ-025 BITWIDTH SHALL come from the shared definitions file used by the register stage; FSM state encodings SHALL be localparams in this module.
REQ-026 SHALL be single module, no sub-modules; the window counter is inline.
REQ-027 All state SHALL be in one clock domain, iClk only; iBit assumed synchronous.

Verification (BITWIDTH=4, window 16)
REQ-028 iStart pulse, iBit=1 for 16 cycles -> oValid at cycle 17, oData=15 (saturated).
REQ-029 iStart pulse, iBit alternating 1,0 -> oData=8; iBit=0 constant -> oData=0, oValid still pulses.
REQ-030 iStart held high continuously, iBit=1 -> oValid pulses every 17 cycles, oData=15 each time; iStart mid-RUN causes no restart.
REQ-031 iClr asserted at RUN cycle 5 -> next cycle IDLE, oBusy=0, oData=0, no oValid.
REQ-032 iRstN low at RUN cycle 10 (asynchronous, mid-cycle) -> outputs 0 immediately; after release with no iStart, oValid stays 0 for 40 cycles.
REQ-033 oValid connected to register iEn, oData to register iData -> register captures 15 after first window of all ones.
